traffic_timer: RTL and testbench
================================

# traffic_timer

Interval timer that serves the traffic-light controller. It accepts a start pulse with a duration in seconds and counts the duration using a clock-derived one-second tick. It reports a sticky completion level, `t_done`, and a flicker square wave, `t_flicker`, during the final seconds of a long interval. The controller drives `t_start`/`t_length` combinationally and samples `t_done`/`t_flicker` on the next clock edge.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: `clk` cycles per second; must be ≥ 2.
- `FLICKER_WINDOW`, default 5'd3: number of final seconds during which flicker is active.
- `FLICKER_HALF`, default `TICKS_PER_SEC/4`: `t_flicker` half-period in cycles; must be ≥ 1.
- `clk`  in  1  system clock; all logic runs on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `t_start`  in  1  load/restart request, sampled every cycle.
- `t_length`  in  5  interval in seconds, sampled only when `t_start`=1.
- `t_done`  out  1  interval expired; registered; held until the next accepted start or reset.
- `t_flicker`  out  1  flicker indication; registered.

## Operation
- FSM states:
  - IDLE: after reset, no interval loaded.
  - RUN: counting.
  - DONE: expired.
- Reset (`reset`=0 at an edge):
  - state ← IDLE.
  - prescaler, `remaining`, and blink counter ← 0.
  - `t_done`=0, `t_flicker`=0.
  - Reset overrides a simultaneous `t_start`.
- Start (`t_start`=1 at an edge, any state):
  - `remaining` ← `t_length`; prescaler ← 0.
  - `flk_en` ← (`t_length` > `FLICKER_WINDOW`).
  - `t_done` ← 0; `t_flicker` ← 0.
  - state ← RUN, or DONE if `t_length`=0.
  - A start during RUN restarts the interval; the old interval is discarded.
- Zero length: `t_length`=0 takes the DONE path, so `t_done`=1 on the edge that accepts the start and `flk_en`=0.
- RUN:
  - The prescaler counts 0..`TICKS_PER_SEC`-1; at wrap it emits a one-cycle `sec_tick`.
  - On `sec_tick`, `remaining` decrements.
  - When `remaining` goes 1→0: state ← DONE, `t_done` ← 1.
- Flicker window, when `flk_en`=1 and 1 ≤ `remaining` ≤ `FLICKER_WINDOW` in RUN:
  - `t_flicker` starts at 1 on the edge where `remaining` becomes `FLICKER_WINDOW`.
  - It inverts every `FLICKER_HALF` cycles.
  - Outside the window, `t_flicker`=0.
- DONE:
  - `t_done`=1; `t_flicker`=`flk_en`.
  - Holding `t_flicker` high guarantees that a controller sitting in its steady-green state reaches its flicker/expiry path.
  - Counters are frozen.
  - Leaves DONE only on start or reset.
- `t_start` while in IDLE or DONE with no change of length behaves identically to any other start.

## Timing
- Start accepted at edge S with length L > 0: `t_done` rises at edge S + L·`TICKS_PER_SEC`.
- `t_flicker` first rises at edge S + (L − `FLICKER_WINDOW`)·`TICKS_PER_SEC`.
- Controller handshake: `t_done` seen at edge D, `t_start` combinational in the same cycle, accepted at edge D+1. `t_done` is therefore 0 after D+1.
- Outputs are registered only; there is no combinational path from input to output.
- Arithmetic widths:
  - `remaining` is 5-bit unsigned and never underflows (no decrement at 0).
  - The prescaler is sized with `$clog2(TICKS_PER_SEC)`; the blink counter with `$clog2(FLICKER_HALF)`.

## Structure
- Shared package `traffic_pkg`:
  - `DUR_W` = 5.
  - `timer_state_t` {IDLE, RUN, DONE}.
  - Default duration constants, shared with the light controller.
- Sub-module `sec_prescaler`:
  - Parameter `TICKS_PER_SEC`.
  - Ports `clk`, `reset`, `clr`, `sec_tick`.
  - Instantiated once; `clr` is driven by an accepted start.

## Test plan
Sim parameters: `TICKS_PER_SEC`=4, `FLICKER_WINDOW`=3, `FLICKER_HALF`=1.
- Reset: hold `reset`=0 for 3 cycles with `t_start`=1 → `t_done`=0 and `t_flicker`=0 throughout; no RUN entry.
- Short interval: start with L=3 at edge S → `t_done`=1 exactly at S+12, `t_flicker`=0 throughout; `t_done` held until the next start, cleared one edge after it.
- Long interval: L=5 at S → `t_flicker` 0 until S+8, then 1,0,1,0… each cycle until S+20; `t_done`=1 and `t_flicker`=1 from S+20 on.
- Restart mid-run: L=10 at S, L=2 at S+7 → `t_done` rises at S+15, not at S+40; `t_flicker` stays 0.
- Zero length and reset mid-run:
  - L=0 → `t_done`=1 on the accepting edge, `t_flicker`=0.
  - L=8 followed by `reset`=0 at S+10 → all outputs 0 from that edge, `t_done` never asserts.
- Closed loop with the light controller: RED 4 s / YELLOW 2 s / GREEN 5 s → the full cycle RED→YELLOW→GREEN (flicker)→YELLOW→RED repeats with the correct cycle counts and no stall in green.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Types and constants shared by the interval timer and the
//                traffic-light controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Width of every duration expressed in seconds
    localparam int DUR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    // Default phase durations in seconds, shared with the light controller
    localparam logic [DUR_W-1:0] c_red_sec    = 5'd4;
    localparam logic [DUR_W-1:0] c_yellow_sec = 5'd2;
    localparam logic [DUR_W-1:0] c_green_sec  = 5'd5;

    // Counter width helper: a counter that only ever holds 0 still needs one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sec_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : sec_prescaler
//  Description : Divides clk down to a one-cycle tick once per second.
//                The count restarts from zero whenever clr is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module sec_prescaler
    import traffic_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic sec_tick
);

    localparam int                 c_cnt_w = clog2_min1(TICKS_PER_SEC);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TICKS_PER_SEC - 1);

    logic [c_cnt_w-1:0] r_count;

    // Tick fires on the last count of each second
    assign sec_tick = (r_count == c_last);

    // Free-running 0..TICKS_PER_SEC-1 counter, restarted by clr
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr || sec_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_timer.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_timer
//  Description : Interval timer for the traffic-light controller. Counts a
//                start-loaded number of seconds, raises a sticky t_done and
//                produces a flicker square wave over the final seconds of a
//                long interval.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int               TICKS_PER_SEC  = 50_000_000,
    parameter logic [DUR_W-1:0] FLICKER_WINDOW = 5'd3,
    parameter int               FLICKER_HALF   = TICKS_PER_SEC / 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_start,
    input  logic [DUR_W-1:0] t_length,
    output logic             t_done,
    output logic             t_flicker
);

    localparam int                   c_blink_w    = clog2_min1(FLICKER_HALF);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(FLICKER_HALF - 1);

    timer_state_t          r_state,     w_state_nxt;
    logic [DUR_W-1:0]      r_remaining, w_remaining_nxt;
    logic [c_blink_w-1:0]  r_blink,     w_blink_nxt;
    logic                  r_flk_en,    w_flk_en_nxt;
    logic                  r_done,      w_done_nxt;
    logic                  r_flicker,   w_flicker_nxt;

    logic w_sec_tick;
    logic w_in_window;
    logic w_enter_window;

    // Prescaler is held at zero outside RUN so the counters stay frozen
    sec_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_sec_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clr      (t_start || (r_state != RUN)),
        .sec_tick (w_sec_tick)
    );

    // Window covers 1..FLICKER_WINDOW remaining seconds; entry is the tick that
    // brings the count down onto FLICKER_WINDOW
    assign w_in_window    = r_flk_en && (r_remaining != '0) && (r_remaining <= FLICKER_WINDOW);
    assign w_enter_window = w_sec_tick && r_flk_en &&
                            ({1'b0, r_remaining} == ({1'b0, FLICKER_WINDOW} + 6'd1));

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_blink_nxt     = r_blink;
        w_flk_en_nxt    = r_flk_en;
        w_done_nxt      = r_done;
        w_flicker_nxt   = r_flicker;

        if (t_start) begin
            // A start always wins, restarting any interval in progress
            w_remaining_nxt = t_length;
            w_flk_en_nxt    = (t_length > FLICKER_WINDOW);
            w_blink_nxt     = '0;
            w_flicker_nxt   = 1'b0;
            w_done_nxt      = (t_length == '0);
            w_state_nxt     = (t_length == '0) ? DONE : RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_sec_tick && (r_remaining != '0)) begin
                        w_remaining_nxt = r_remaining - 1'b1;
                    end
                    if (w_sec_tick && (r_remaining == 5'd1)) begin
                        w_state_nxt   = DONE;
                        w_done_nxt    = 1'b1;
                        w_flicker_nxt = r_flk_en;
                    end else if (w_enter_window) begin
                        w_flicker_nxt = 1'b1;
                        w_blink_nxt   = '0;
                    end else if (w_in_window) begin
                        if (r_blink == c_blink_last) begin
                            w_flicker_nxt = ~r_flicker;
                            w_blink_nxt   = '0;
                        end else begin
                            w_blink_nxt   = r_blink + c_blink_w'(1);
                        end
                    end else begin
                        w_flicker_nxt = 1'b0;
                    end
                end
                DONE: begin
                    // Flicker stays high so a waiting green phase still expires
                    w_done_nxt    = 1'b1;
                    w_flicker_nxt = r_flk_en;
                end
                default: begin
                    w_done_nxt    = 1'b0;
                    w_flicker_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_blink     <= '0;
            r_flk_en    <= 1'b0;
            r_done      <= 1'b0;
            r_flicker   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_blink     <= w_blink_nxt;
            r_flk_en    <= w_flk_en_nxt;
            r_done      <= w_done_nxt;
            r_flicker   <= w_flicker_nxt;
        end
    end

    assign t_done    = r_done;
    assign t_flicker = r_flicker;

endmodule
`default_nettype wire

// File: tb/tb_traffic_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_timer
//  Description : Self-checking bench for traffic_timer with a timeline-based
//                reference model and a closed-loop light controller model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_timer;
    import traffic_pkg::*;

    localparam int c_tps  = 4;
    localparam int c_win  = 3;
    localparam int c_half = 1;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       t_start  = 1'b0;
    logic [4:0] t_length = 5'd0;
    logic       t_done;
    logic       t_flicker;

    int checks = 0;
    int errors = 0;

    // Reference model: just the start edge and length of the live interval
    int edge_n   = 0;
    bit m_active = 1'b0;
    int m_s      = 0;
    int m_len    = 0;

    traffic_timer #(
        .TICKS_PER_SEC  (c_tps),
        .FLICKER_WINDOW (5'd3),
        .FLICKER_HALF   (c_half)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .t_start   (t_start),
        .t_length  (t_length),
        .t_done    (t_done),
        .t_flicker (t_flicker)
    );

    always #5 clk = ~clk;

    // Expected outputs from elapsed time since the accepted start
    function automatic void model_out(output logic d, output logic f);
        int e;
        int fstart;
        d = 1'b0;
        f = 1'b0;
        if (m_active) begin
            e = edge_n - m_s;
            if (m_len == 0) begin
                d = 1'b1;
            end else if (e >= m_len * c_tps) begin
                d = 1'b1;
                f = (m_len > c_win);
            end else if (m_len > c_win) begin
                fstart = (m_len - c_win) * c_tps;
                if (e >= fstart) f = (((e - fstart) / c_half) % 2) == 0;
            end
        end
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge: update the model from the sampled inputs, then compare
    task automatic step();
        logic ed, ef;
        @(posedge clk);
        edge_n++;
        if (!reset) begin
            m_active = 1'b0;
        end else if (t_start) begin
            m_active = 1'b1;
            m_s      = edge_n;
            m_len    = int'(t_length);
        end
        #1;
        model_out(ed, ef);
        check("t_done", t_done, ed);
        check("t_flicker", t_flicker, ef);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int s_edge;
        int rise;
        int idx;
        bit flk_seen;
        int red_edges[$];
        int plen[4];

        // Reset held with a start request pending
        reset = 1'b0; t_start = 1'b1; t_length = 5'd5;
        steps(3);
        reset = 1'b1; t_start = 1'b0;
        steps(4);

        // Short interval L=3: done exactly 12 edges after the start
        t_start = 1'b1; t_length = 5'd3;
        step(); s_edge = edge_n; t_start = 1'b0;
        rise = -1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (t_done && rise < 0) rise = edge_n;
        end
        check_int("short_done_edge", rise - s_edge, 12);
        t_start = 1'b1; t_length = 5'd3;
        step(); t_start = 1'b0;
        check("short_done_cleared", t_done, 1'b0);
        steps(2);

        // Long interval L=5: flicker from S+8, done and flicker high from S+20
        t_start = 1'b1; t_length = 5'd5;
        step(); s_edge = edge_n; t_start = 1'b0;
        rise = -1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (t_flicker && rise < 0) rise = edge_n;
        end
        check_int("long_flicker_start", rise - s_edge, 8);

        // Restart mid-run: L=10 then L=2 seven edges later
        t_start = 1'b1; t_length = 5'd10;
        step(); s_edge = edge_n; t_start = 1'b0;
        steps(6);
        t_start = 1'b1; t_length = 5'd2;
        step(); t_start = 1'b0;
        rise = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (t_done && rise < 0) rise = edge_n;
        end
        check_int("restart_done_edge", rise - s_edge, 15);

        // Zero length completes on the accepting edge
        t_start = 1'b1; t_length = 5'd0;
        step(); t_start = 1'b0;
        check("zero_len_done", t_done, 1'b1);
        steps(3);

        // Reset mid-run aborts the interval
        t_start = 1'b1; t_length = 5'd8;
        step(); t_start = 1'b0;
        steps(9);
        reset = 1'b0;
        step();
        reset = 1'b1;
        steps(40);

        // Randomized starts, lengths and resets
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            t_start  = ($urandom_range(0, 99) < 4);
            t_length = 5'($urandom_range(0, 9));
            step();
        end
        reset = 1'b1; t_start = 1'b0;

        // Closed loop with a light controller: RED, YELLOW, GREEN, YELLOW
        plen[0] = int'(c_red_sec);
        plen[1] = int'(c_yellow_sec);
        plen[2] = int'(c_green_sec);
        plen[3] = int'(c_yellow_sec);
        idx = 0;
        flk_seen = 1'b0;
        t_start = 1'b1; t_length = c_red_sec;
        step(); red_edges.push_back(edge_n);
        t_start = 1'b0;
        for (int i = 0; i < 400 && red_edges.size() < 3; i++) begin
            if (t_start && idx == 0) red_edges.push_back(edge_n + 1);
            step();
            if (idx == 2 && t_flicker && !t_done) flk_seen = 1'b1;
            if (t_done && !t_start) begin
                if (idx == 2) begin
                    check("green_flicker_seen", flk_seen, 1'b1);
                    flk_seen = 1'b0;
                end
                idx      = (idx + 1) % 4;
                t_start  = 1'b1;
                t_length = 5'(plen[idx]);
            end else begin
                t_start = 1'b0;
            end
        end
        check_int("loop_red_starts", red_edges.size(), 3);
        if (red_edges.size() >= 3) begin
            check_int("loop_period_1", red_edges[1] - red_edges[0], 56);
            check_int("loop_period_2", red_edges[2] - red_edges[1], 56);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
